// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation run-control sequencer.
// Replaces the old def_params.v state macros and counter-width default.
package sim_ctrl_pkg;

  localparam int unsigned SC_CNT_WIDTH = 32;

  typedef enum logic [2:0] {
    SC_HOLD  = 3'd0,
    SC_RUN   = 3'd1,
    SC_DRAIN = 3'd2,
    SC_DUMP  = 3'd3,
    SC_DONE  = 3'd4
  } sc_state_t;

endpackage

// File: rtl/sim_ctrl_down_counter.sv
// Loadable down-counter with zero flag; one instance is shared by the
// HOLD, DRAIN and DUMP phases of sim_ctrl.
module sc_down_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sim_ctrl.sv
// Run-control sequencer: holds the core(s) in reset, runs until halt or
// watchdog timeout, drains outstanding stores, pulses finish, then reports done.
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned NUM_HARTS      = 1,
  parameter int unsigned HALT_MODE      = 0,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter int unsigned DUMP_CYCLES    = 1,
  parameter int unsigned CNT_WIDTH      = SC_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HARTS-1:0] halt,
  output logic                 core_reset,
  output logic                 finish,
  output logic                 done,
  output logic                 timeout,
  output logic [NUM_HARTS-1:0] halted_mask,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam logic [CNT_WIDTH-1:0] RESET_LD = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LD =
    CNT_WIDTH'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DUMP_LD  = CNT_WIDTH'(DUMP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  =
    CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

`ifdef SIMULATE
  if (((longint'(RESET_CYCLES)   >> CNT_WIDTH) != 0) ||
      ((longint'(TIMEOUT_CYCLES) >> CNT_WIDTH) != 0) ||
      ((longint'(DRAIN_CYCLES)   >> CNT_WIDTH) != 0) ||
      ((longint'(DUMP_CYCLES)    >> CNT_WIDTH) != 0) ||
      (RESET_CYCLES == 0) || (DUMP_CYCLES == 0)) begin : g_param_check
    $error("sim_ctrl: cycle parameters out of range for CNT_WIDTH=%0d", CNT_WIDTH);
  end
`endif

  sc_state_t              state;
  logic [NUM_HARTS-1:0]   seen;
  logic                   end_halt;
  logic                   end_to;
  logic                   end_run;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic [CNT_WIDTH-1:0]   cnt_value;
  logic [CNT_WIDTH-1:0]   cnt_count;
  logic                   cnt_zero;

  // Current-cycle halt counts toward the end condition.
  always_comb begin
    seen     = halted_mask | halt;
    end_halt = (HALT_MODE == 0) ? (&seen) : (|halt);
    end_to   = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST);
    end_run  = end_halt || end_to;
  end

  // Reset preloads the HOLD length so HOLD needs no separate entry cycle.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_value = '0;
    if (reset) begin
      cnt_load  = 1'b1;
      cnt_value = RESET_LD;
    end else begin
      case (state)
        SC_HOLD, SC_DUMP: cnt_dec = !cnt_zero;
        SC_RUN: begin
          if (end_run) begin
            cnt_load  = 1'b1;
            cnt_value = (DRAIN_CYCLES == 0) ? DUMP_LD : DRAIN_LD;
          end
        end
        SC_DRAIN: begin
          if (cnt_zero) begin
            cnt_load  = 1'b1;
            cnt_value = DUMP_LD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sc_down_counter #(.WIDTH(CNT_WIDTH)) u_phase_cnt (
    .clk        (clk),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .count      (cnt_count),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SC_HOLD;
      core_reset  <= 1'b1;
      finish      <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      halted_mask <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        SC_HOLD: begin
          if (cnt_zero) begin
            state      <= SC_RUN;
            core_reset <= 1'b0;
          end
        end
        SC_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + CNT_WIDTH'(1);
          halted_mask <= seen;
          if (end_run) begin
            timeout <= !end_halt;
            if (DRAIN_CYCLES == 0) begin
              state      <= SC_DUMP;
              finish     <= 1'b1;
              core_reset <= 1'b1;
            end else begin
              state <= SC_DRAIN;
            end
          end
        end
        SC_DRAIN: begin
          if (cnt_zero) begin
            state      <= SC_DUMP;
            finish     <= 1'b1;
            core_reset <= 1'b1;
          end
        end
        SC_DUMP: begin
          if (cnt_zero) begin
            state  <= SC_DONE;
            finish <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SIMULATE
  sc_state_t state_q;
  always_ff @(posedge clk) begin
    state_q <= state;
    if (state == SC_DUMP && state_q != SC_DUMP)
      $display("sim_ctrl: run ended by %s at cycle_count=%0d",
               timeout ? "watchdog" : "halt", cycle_count);
  end
`endif

endmodule

// File: tb/tb_sim_ctrl.sv
// Self-checking bench for sim_ctrl: three parameterisations driven one at a
// time, each cycle compared against a timeline model of the run.
module tb_sim_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [3:0] halt_a = '0, halt_b = '0;
  logic [0:0] halt_c = '0;
  logic       cr_a, fin_a, dn_a, to_a;
  logic       cr_b, fin_b, dn_b, to_b;
  logic       cr_c, fin_c, dn_c, to_c;
  logic [3:0] hm_a, hm_b;
  logic [0:0] hm_c;
  logic [31:0] cc_a;
  logic [15:0] cc_b;
  logic [3:0]  cc_c;

  // A: all-halt with watchdog, long dump; B: any-halt, no drain; C: 1 hart, 4-bit counter.
  sim_ctrl #(.NUM_HARTS(4), .HALT_MODE(0), .RESET_CYCLES(2), .TIMEOUT_CYCLES(50),
             .DRAIN_CYCLES(4), .DUMP_CYCLES(3), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .reset(rst_a), .halt(halt_a), .core_reset(cr_a), .finish(fin_a),
    .done(dn_a), .timeout(to_a), .halted_mask(hm_a), .cycle_count(cc_a));

  sim_ctrl #(.NUM_HARTS(4), .HALT_MODE(1), .RESET_CYCLES(3), .TIMEOUT_CYCLES(0),
             .DRAIN_CYCLES(0), .DUMP_CYCLES(1), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset(rst_b), .halt(halt_b), .core_reset(cr_b), .finish(fin_b),
    .done(dn_b), .timeout(to_b), .halted_mask(hm_b), .cycle_count(cc_b));

  sim_ctrl #(.NUM_HARTS(1), .HALT_MODE(0), .RESET_CYCLES(2), .TIMEOUT_CYCLES(0),
             .DRAIN_CYCLES(4), .DUMP_CYCLES(1), .CNT_WIDTH(4)) dut_c (
    .clk(clk), .reset(rst_c), .halt(halt_c), .core_reset(cr_c), .finish(fin_c),
    .done(dn_c), .timeout(to_c), .halted_mask(hm_c), .cycle_count(cc_c));

  int cfg_nh   [3] = '{4, 4, 1};
  int cfg_mode [3] = '{0, 1, 0};
  int cfg_rst  [3] = '{2, 3, 2};
  int cfg_to   [3] = '{50, 0, 0};
  int cfg_drn  [3] = '{4, 0, 4};
  int cfg_dmp  [3] = '{3, 1, 1};
  int cfg_w    [3] = '{32, 16, 4};

  localparam int HMAX = 128;
  localparam logic [39:0] RESET_VEC = {1'b1, 39'd0};

  logic [3:0] hpat [HMAX];
  int passed = 0;
  int total  = 0;
  int cur_sel = 0;
  logic [39:0] obs;

  // Observed vector: {core_reset, finish, done, timeout, halted_mask[3:0], cycle_count[31:0]}
  always_comb begin
    case (cur_sel)
      0:       obs = {cr_a, fin_a, dn_a, to_a, hm_a, cc_a};
      1:       obs = {cr_b, fin_b, dn_b, to_b, hm_b, 16'd0, cc_b};
      default: obs = {cr_c, fin_c, dn_c, to_c, 3'd0, hm_c, 28'd0, cc_c};
    endcase
  end

  task automatic set_rst(input int sel, input logic v);
    case (sel)
      0: rst_a = v;
      1: rst_b = v;
      default: rst_c = v;
    endcase
  endtask

  task automatic set_halt(input int sel, input logic [3:0] v);
    case (sel)
      0: halt_a = v;
      1: halt_b = v;
      default: halt_c = v[0];
    endcase
  endtask

  task automatic clear_pat();
    for (int i = 0; i < HMAX; i++) hpat[i] = '0;
  endtask

  // Run-level model: first RUN cycle whose halts satisfy the end rule, or the watchdog.
  task automatic model_end(input int sel, output int t, output logic to_flag);
    logic [3:0] full, acc, h;
    full = 4'((1 << cfg_nh[sel]) - 1);
    acc = '0; t = -1; to_flag = 1'b0;
    for (int k = 0; k < HMAX; k++) begin
      h = hpat[k] & full;
      acc = acc | h;
      if ((cfg_mode[sel] == 0) ? (acc == full) : (h != 0)) begin
        t = k; break;
      end
      if (cfg_to[sel] != 0 && k == cfg_to[sel] - 1) begin
        t = k; to_flag = 1'b1; break;
      end
    end
  endtask

  // Reset the selected DUT, then compare every cycle with the model timeline.
  // abort_n >= 0 re-asserts reset after that cycle and checks the reset state.
  task automatic run_case(input string name, input int sel, input logic [3:0] hold_halt,
                          input int n_max, input int abort_n);
    int t, r, d, u, e, n_end, upto;
    logic to_flag, cr, fin, dn, tof;
    logic [3:0] m, full;
    longint c, maxc;
    logic [39:0] expv;
    model_end(sel, t, to_flag);
    r = cfg_rst[sel]; d = cfg_drn[sel]; u = cfg_dmp[sel];
    full = 4'((1 << cfg_nh[sel]) - 1);
    maxc = (longint'(1) << cfg_w[sel]) - 1;
    e = (t >= 0) ? r + t + 1 : 32'h3fff_ffff;
    n_end = (t >= 0) ? e + d + u + 3 : n_max;
    cur_sel = sel;
    set_halt(sel, hold_halt);
    set_rst(sel, 1'b1);
    @(posedge clk); #1;
    set_rst(sel, 1'b0);
    for (int n = 0; n < n_end; n++) begin
      cr  = !(n >= r && n < e + d);
      fin = (n >= e + d) && (n < e + d + u);
      dn  = (n >= e + d + u);
      tof = (n >= e) ? to_flag : 1'b0;
      upto = (n <= r) ? 0 : ((n < e) ? n - r : t + 1);
      m = '0;
      for (int j = 0; j < upto && j < HMAX; j++) m = m | (hpat[j] & full);
      c = (n < r) ? 0 : ((n < e) ? longint'(n - r) : longint'(t + 1));
      if (c > maxc) c = maxc;
      expv = {cr, fin, dn, tof, m, 32'(c)};
      total++;
      if (obs !== expv) $display("FAIL %s cycle %0d: got %h want %h", name, n, obs, expv);
      else passed++;
      if (n == abort_n) begin
        set_rst(sel, 1'b1);
        @(posedge clk); #1;
        total++;
        if (obs !== RESET_VEC) $display("FAIL %s reset_abort: got %h want %h", name, obs, RESET_VEC);
        else passed++;
        set_rst(sel, 1'b0);
        set_halt(sel, '0);
        return;
      end
      if (n < r) set_halt(sel, hold_halt);
      else if (n - r < HMAX) set_halt(sel, hpat[n - r]);
      else set_halt(sel, '0);
      @(posedge clk); #1;
    end
    set_halt(sel, '0);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      cur_sel = s;
      set_rst(s, 1'b1);
      @(posedge clk); #1;
      total++;
      if (obs !== RESET_VEC) $display("FAIL reset_state dut%0d: got %h want %h", s, obs, RESET_VEC);
      else passed++;
    end
  endtask

  task automatic test_single_halt();
    clear_pat();
    for (int i = 10; i < HMAX; i++) hpat[i] = 4'b0001;
    run_case("single_halt", 2, '0, 0, -1);
    total++;
    if (obs[31:0] !== 32'd11 || obs[37] !== 1'b1 || obs[36] !== 1'b0)
      $display("FAIL single_halt_final: got %h want count 11 done 1 timeout 0", obs);
    else passed++;
  endtask

  task automatic test_all_halt();
    clear_pat();
    hpat[5] = 4'b0001; hpat[8] = 4'b0100; hpat[12] = 4'b0010; hpat[20] = 4'b1000;
    run_case("all_halt", 0, '0, 0, -1);
    total++;
    if (obs[35:32] !== 4'b1111 || obs[31:0] !== 32'd21)
      $display("FAIL all_halt_final: got %h want mask f count 21", obs);
    else passed++;
  endtask

  task automatic test_any_halt();
    clear_pat();
    hpat[5] = 4'b0001; hpat[8] = 4'b0100; hpat[12] = 4'b0010; hpat[20] = 4'b1000;
    run_case("any_halt", 1, '0, 0, -1);
    total++;
    if (obs[35:32] !== 4'b0001 || obs[31:0] !== 32'd6)
      $display("FAIL any_halt_final: got %h want mask 1 count 6", obs);
    else passed++;
  endtask

  task automatic test_timeout();
    clear_pat();
    hpat[10] = 4'b0011;
    run_case("timeout", 0, '0, 0, -1);
    total++;
    if (obs[36] !== 1'b1 || obs[31:0] !== 32'd50)
      $display("FAIL timeout_final: got %h want timeout 1 count 50", obs);
    else passed++;
    clear_pat();
    hpat[49] = 4'b1111;
    run_case("timeout_vs_halt", 0, '0, 0, -1);
    total++;
    if (obs[36] !== 1'b0 || obs[31:0] !== 32'd50)
      $display("FAIL timeout_vs_halt_final: got %h want timeout 0 count 50", obs);
    else passed++;
  endtask

  task automatic test_reset_in_dump();
    clear_pat();
    hpat[7] = 4'b1111;
    // End at run cycle 7: DUMP occupies cycles 14..16, abort in the second.
    run_case("reset_in_dump", 0, '0, 0, 15);
    hpat[7] = 4'b0000; hpat[9] = 4'b1111;
    run_case("after_abort", 0, '0, 0, -1);
  endtask

  task automatic test_hold_halt_saturate();
    clear_pat();
    run_case("hold_halt_saturate", 2, 4'b0001, 40, -1);
    total++;
    if (obs[31:0] !== 32'd15 || obs[35:32] !== 4'b0000)
      $display("FAIL saturate_final: got %h want count f mask 0", obs);
    else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      clear_pat();
      for (int i = 0; i < 60; i++)
        if ($urandom_range(0, 5) == 0) hpat[i] = 4'($urandom);
      run_case("random_all", 0, 4'($urandom), 0, -1);
      clear_pat();
      for (int i = $urandom_range(0, 30); i < 60; i++)
        if ($urandom_range(0, 3) == 0) hpat[i] = 4'($urandom);
      run_case("random_any", 1, 4'($urandom), 80, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_halt();
    test_all_halt();
    test_any_halt();
    test_timeout();
    test_reset_in_dump();
    test_hold_halt_saturate();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
